lru_access_arbiter: RTL
=======================

LRU_ACCESS_ARBITER -- requirements
Module: lru_access_arbiter

Interface
REQ-001 Parameters: none; set count fixed at 128 (7-bit index), ways fixed at 8 (one-hot 8-bit).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_req_valid_2  input  2  per-requester request valid; bit0 = requester 0, bit1 = requester 1.
REQ-005 o_req_ready_2  output  2  per-requester accept strobe; a request transfers when valid and ready are both 1.
REQ-006 i_req0_addr_7 / i_req1_addr_7  input  7 each  set index of the request.
REQ-007 i_req0_hit_sig / i_req1_hit_sig  input  1 each  1 = hit, 0 = miss.
REQ-008 i_req0_hit_way_8 / i_req1_hit_way_8  input  8 each  one-hot hit way, meaningful only when hit_sig = 1.
REQ-009 o_lru_addr_7  output  7  set index driven to the LRU state array.
REQ-010 o_lru_hit_sig  output  1  hit/miss driven to the LRU state array.
REQ-011 o_lru_hit_way_8  output  8  hit way driven to the LRU state array.
REQ-012 o_lru_we  output  1  write enable for the LRU state array; the array updates set o_lru_addr_7 only when we = 1.
REQ-013 o_lru_init  output  1  1 = the array loads its reset ordering into set o_lru_addr_7 this cycle.
REQ-014 i_lru_flag_8  input  8  combinational one-hot LRU flag for set o_lru_addr_7.
REQ-015 i_init_start  input  1  pulse; requests a full LRU state re-initialisation sweep.
REQ-016 o_resp_valid  output  1  response valid.
REQ-017 i_resp_ready  input  1  response accept.
REQ-018 o_resp_id  output  1  requester that owns the response.
REQ-019 o_resp_victim_8  output  8  one-hot victim way (miss) or echoed hit way (hit).
REQ-020 o_resp_err  output  1  1 = request had hit_sig = 1 with a hit_way that was not one-hot.
REQ-021 o_busy  output  1  1 whenever the state is not IDLE.

Function
REQ-022 The FSM SHALL have five states: IDLE, LOOKUP, COMMIT, RESP, INIT.
REQ-023 In IDLE with any request valid and no pending init, the block SHALL assert ready for exactly one requester for one cycle, latch that requester's addr/hit_sig/hit_way/id, and go to LOOKUP.
REQ-024 Arbitration SHALL be round-robin: priority pointer starts at requester 0 and moves to the other requester after each grant; a lone valid requester is always granted.
REQ-025 In LOOKUP, o_lru_addr_7 SHALL carry the latched index with o_lru_we = 0, and the block SHALL capture the victim from i_lru_flag_8: lowest set bit, or 8'b1000_0000 when the flag is all zero.
REQ-026 In COMMIT, the block SHALL drive o_lru_we = 1 for one cycle with the latched index, hit_sig and hit_way, then go to RESP. If o_resp_err applies, o_lru_we SHALL stay 0.
REQ-027 In RESP, o_resp_valid SHALL be 1 and held stable until i_resp_ready = 1; then go to IDLE, or to INIT when an init is pending.
REQ-028 o_resp_victim_8 SHALL equal the latched hit_way on a hit and the captured victim on a miss.
REQ-029 Latency: grant to o_resp_valid SHALL be 3 cycles, and a new grant SHALL occur no earlier than the cycle after the response handshake.
REQ-030 i_init_start SHALL set a sticky pending flag. INIT SHALL be entered from IDLE, or after RESP completes, and has priority over new requests.
REQ-031 In INIT, a 7-bit counter SHALL drive o_lru_addr_7 from 0 to 127 with o_lru_init = 1 and o_lru_we = 0, one set per cycle, then clear the pending flag and return to IDLE (128 cycles); o_req_ready_2 SHALL be 0 throughout.
REQ-032 An i_init_start during INIT SHALL be ignored.
REQ-033 Outside LOOKUP/COMMIT/INIT, o_lru_we and o_lru_init SHALL be 0 and o_lru_addr_7 SHALL hold its last value.
REQ-034 o_req_ready_2 SHALL never have both bits set and SHALL be 0 in every state except the IDLE grant cycle.

Reset
REQ-035 On rst = 1 at a clock edge the block SHALL enter IDLE and clear the round-robin pointer (to requester 0), the init-pending flag, the counter and all latches; outputs SHALL be 0 except o_lru_addr_7 = 0.
REQ-036 A reset asserted mid-operation (LOOKUP, COMMIT, RESP, INIT) SHALL abort it with no further o_lru_we, o_lru_init or o_resp_valid pulse.

Verification
REQ-037 Single miss: req0 addr 5, hit_sig 0, flag 8'b0000_0100 -> o_lru_we pulse at addr 5 with hit_sig 0; resp id 0, victim 8'b0000_0100, 3 cycles after grant.
REQ-038 Contention: both valid continuously -> grants alternate 0,1,0,1 and each ready bit is a single-cycle pulse.
REQ-039 Hit with bad way: hit_sig 1, hit_way 8'b0001_0100 -> o_resp_err 1, no o_lru_we pulse.
REQ-040 Zero flag on miss: flag 8'h00 -> victim 8'h80. Multiple flags 8'b0001_0010 -> victim 8'b0000_0010.
REQ-041 Init during RESP with i_resp_ready held 0 for 4 cycles -> after the handshake, 128 o_lru_init cycles with addr 0..127 and no grants; then a new grant is allowed.
REQ-042 Reset during INIT at addr 60 -> IDLE next cycle, o_lru_init 0, pending flag clear.

Source files
------------

// File: rtl/lru_access_arbiter.sv
// lru_access_arbiter: two-requester round-robin front end for a 128-set x 8-way
// LRU state array. Each accepted request runs LOOKUP -> COMMIT -> RESP; a pulse
// on i_init_start queues a full sweep that reloads every set's reset ordering.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   i_req_valid_2            per-requester request valid (bit n = requester n)
//   o_req_ready_2            per-requester accept strobe (combinational, IDLE only)
//   i_reqN_addr_7            set index of requester N
//   i_reqN_hit_sig           1 = hit, 0 = miss
//   i_reqN_hit_way_8         one-hot hit way (valid when hit_sig = 1)
//   o_lru_addr_7             set index to the LRU array
//   o_lru_hit_sig            hit/miss to the LRU array
//   o_lru_hit_way_8          hit way to the LRU array
//   o_lru_we                 LRU array update strobe
//   o_lru_init               LRU array reset-ordering load strobe
//   i_lru_flag_8             one-hot LRU flag of set o_lru_addr_7
//   i_init_start             request a full re-initialisation sweep
//   o_resp_valid/i_resp_ready response handshake
//   o_resp_id                requester owning the response
//   o_resp_victim_8          victim way (miss) or echoed hit way (hit)
//   o_resp_err               hit with a non-one-hot hit way
//   o_busy                   state is not IDLE
module lru_access_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req_valid_2,
  output logic [1:0] o_req_ready_2,
  input  logic [6:0] i_req0_addr_7,
  input  logic [6:0] i_req1_addr_7,
  input  logic       i_req0_hit_sig,
  input  logic       i_req1_hit_sig,
  input  logic [7:0] i_req0_hit_way_8,
  input  logic [7:0] i_req1_hit_way_8,
  output logic [6:0] o_lru_addr_7,
  output logic       o_lru_hit_sig,
  output logic [7:0] o_lru_hit_way_8,
  output logic       o_lru_we,
  output logic       o_lru_init,
  input  logic [7:0] i_lru_flag_8,
  input  logic       i_init_start,
  output logic       o_resp_valid,
  input  logic       i_resp_ready,
  output logic       o_resp_id,
  output logic [7:0] o_resp_victim_8,
  output logic       o_resp_err,
  output logic       o_busy
);

  localparam int unsigned IDX_W = 7;
  localparam int unsigned WAY_W = 8;
  localparam int unsigned SET_N = 128;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_COMMIT = 3'd2,
    S_RESP   = 3'd3,
    S_INIT   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_prio;
  logic               r_init_pend;
  logic [IDX_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_lru_addr;
  logic               r_lru_hit;
  logic [WAY_W-1:0]   r_lru_way;
  logic               r_lru_we;
  logic               r_lru_init;
  logic               r_resp_valid;
  logic               r_resp_id;
  logic [WAY_W-1:0]   r_resp_victim;
  logic               r_resp_err;
  logic               r_busy;

  logic [1:0]         w_gnt;
  logic               w_gnt_id;
  logic [IDX_W-1:0]   w_sel_addr;
  logic               w_sel_hit;
  logic [WAY_W-1:0]   w_sel_way;
  logic               w_sel_err;
  logic [WAY_W-1:0]   w_flag_low;
  logic [WAY_W-1:0]   w_victim;
  logic [IDX_W-1:0]   w_cnt_nxt;
  logic               w_sweep_done;

  // Next-state and grant decode; a pending init always wins over requests
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt        = 2'b00;
    w_gnt_id     = 1'b0;
    w_sweep_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_init_pend) begin
          w_state_nxt = S_INIT;
        end else if (|i_req_valid_2) begin
          w_state_nxt = S_LOOKUP;
          w_gnt_id    = (i_req_valid_2 == 2'b11) ? r_prio : i_req_valid_2[1];
          w_gnt       = w_gnt_id ? 2'b10 : 2'b01;
        end
      end
      S_LOOKUP: w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_RESP;
      S_RESP: begin
        if (i_resp_ready) begin
          w_state_nxt = r_init_pend ? S_INIT : S_IDLE;
        end
      end
      S_INIT: begin
        if (r_cnt == IDX_W'(SET_N - 1)) begin
          w_state_nxt  = S_IDLE;
          w_sweep_done = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_req_ready_2 = w_gnt;

  // Granted requester's payload and its hit-way sanity check
  assign w_sel_addr = w_gnt_id ? i_req1_addr_7    : i_req0_addr_7;
  assign w_sel_hit  = w_gnt_id ? i_req1_hit_sig   : i_req0_hit_sig;
  assign w_sel_way  = w_gnt_id ? i_req1_hit_way_8 : i_req0_hit_way_8;
  assign w_sel_err  = w_sel_hit &&
                      ((w_sel_way == '0) || ((w_sel_way & (w_sel_way - WAY_W'(1))) != '0));

  // Lowest set flag bit; an empty flag falls back to the top way
  assign w_flag_low = i_lru_flag_8 & (~i_lru_flag_8 + WAY_W'(1));
  assign w_victim   = (i_lru_flag_8 == '0) ? {1'b1, {(WAY_W-1){1'b0}}} : w_flag_low;

  // Sweep counter restarts at 0 on INIT entry
  assign w_cnt_nxt = (r_state == S_INIT) ? (r_cnt + IDX_W'(1)) : '0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio        <= 1'b0;
      r_init_pend   <= 1'b0;
      r_cnt         <= '0;
      r_lru_addr    <= '0;
      r_lru_hit     <= 1'b0;
      r_lru_way     <= '0;
      r_lru_we      <= 1'b0;
      r_lru_init    <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_id     <= 1'b0;
      r_resp_victim <= '0;
      r_resp_err    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_busy       <= (w_state_nxt != S_IDLE);
      r_lru_we     <= (w_state_nxt == S_COMMIT) && !r_resp_err;
      r_lru_init   <= (w_state_nxt == S_INIT);
      r_resp_valid <= (w_state_nxt == S_RESP);

      if (|w_gnt) begin
        r_prio     <= ~r_prio;
        r_lru_addr <= w_sel_addr;
        r_lru_hit  <= w_sel_hit;
        r_lru_way  <= w_sel_way;
        r_resp_id  <= w_gnt_id;
        r_resp_err <= w_sel_err;
      end

      if (r_state == S_LOOKUP) begin
        r_resp_victim <= r_lru_hit ? r_lru_way : w_victim;
      end

      if (w_state_nxt == S_INIT) begin
        r_cnt      <= w_cnt_nxt;
        r_lru_addr <= w_cnt_nxt;
      end

      // Starts arriving during a sweep are dropped
      if (w_sweep_done) begin
        r_init_pend <= 1'b0;
      end else if (i_init_start && (r_state != S_INIT)) begin
        r_init_pend <= 1'b1;
      end
    end
  end

  assign o_lru_addr_7    = r_lru_addr;
  assign o_lru_hit_sig   = r_lru_hit;
  assign o_lru_hit_way_8 = r_lru_way;
  assign o_lru_we        = r_lru_we;
  assign o_lru_init      = r_lru_init;
  assign o_resp_valid    = r_resp_valid;
  assign o_resp_id       = r_resp_id;
  assign o_resp_victim_8 = r_resp_victim;
  assign o_resp_err      = r_resp_err;
  assign o_busy          = r_busy;

endmodule
